// File: rtl/platform_renderer.sv
// Platform strip renderer: maps raster coordinates plus horizontal scroll to platform_rom
// tile addresses, then keys out the transparent colour and composites over the background.
module platform_renderer #(
    parameter int          H_ACTIVE    = 640,
    parameter int          PLAT_Y_TOP  = 416,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        scroll_en,
    input  logic [2:0]  scroll_speed,
    input  logic [11:0] bg_color,
    output logic [5:0]  rom_x,
    output logic [4:0]  rom_y,
    output logic        rom_en,
    input  logic [11:0] rom_color,
    output logic [11:0] pix_color,
    output logic        pix_valid,
    output logic        in_platform
);

    localparam logic [9:0] H_LIMIT = 10'(H_ACTIVE);
    localparam logic [9:0] Y_TOP   = 10'(PLAT_Y_TOP);
    localparam logic [9:0] Y_BOT   = 10'(PLAT_Y_TOP + 31);

    logic [5:0]  scroll_q, scroll_d;
    logic [5:0]  romX_q, romX_d;
    logic [4:0]  romY_q, romY_d;
    logic        romEn_q;
    logic        hit1_q, hit2_q, hit3_q, hit1_d;
    logic        vld1_q, vld2_q, vld3_q;
    logic [11:0] bg1_q, bg2_q, bg3_q;
    logic [11:0] pixColor_q, pixColor_d;
    logic        pixValid_q, pixValid_d;
    logic        inPlat_q, inPlat_d;

    // Scroll advance and stage-1 address/hit computation
    always_comb begin
        scroll_d = scroll_q;
        if (frame_tick && scroll_en)
            scroll_d = scroll_q + {3'b000, scroll_speed};
        romX_d = hcount[5:0] + scroll_q;
        romY_d = vcount[4:0] - Y_TOP[4:0];
        hit1_d = video_on && (hcount < H_LIMIT) && (vcount >= Y_TOP) && (vcount <= Y_BOT);
    end

    // Output stage: rom_color arrives aligned with stage 3
    always_comb begin
        pixColor_d = 12'h000;
        pixValid_d = 1'b0;
        inPlat_d   = 1'b0;
        if (vld3_q) begin
            pixValid_d = 1'b1;
            if (hit3_q && (rom_color != TRANSPARENT)) begin
                pixColor_d = rom_color;
                inPlat_d   = 1'b1;
            end else begin
                pixColor_d = bg3_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scroll_q   <= 6'd0;
            romX_q     <= 6'd0;
            romY_q     <= 5'd0;
            romEn_q    <= 1'b0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            hit3_q     <= 1'b0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            vld3_q     <= 1'b0;
            bg1_q      <= 12'h000;
            bg2_q      <= 12'h000;
            bg3_q      <= 12'h000;
            pixColor_q <= 12'h000;
            pixValid_q <= 1'b0;
            inPlat_q   <= 1'b0;
        end else begin
            scroll_q   <= scroll_d;
            romX_q     <= romX_d;
            romY_q     <= romY_d;
            romEn_q    <= 1'b1;
            hit1_q     <= hit1_d;
            hit2_q     <= hit1_q;
            hit3_q     <= hit2_q;
            vld1_q     <= video_on;
            vld2_q     <= vld1_q;
            vld3_q     <= vld2_q;
            bg1_q      <= bg_color;
            bg2_q      <= bg1_q;
            bg3_q      <= bg2_q;
            pixColor_q <= pixColor_d;
            pixValid_q <= pixValid_d;
            inPlat_q   <= inPlat_d;
        end
    end

    assign rom_x       = romX_q;
    assign rom_y       = romY_q;
    assign rom_en      = romEn_q;
    assign pix_color   = pixColor_q;
    assign pix_valid   = pixValid_q;
    assign in_platform = inPlat_q;

endmodule

// File: tb/tb_platform_renderer.sv
// Directed bench for platform_renderer with a 2-cycle-latency platform_rom model that returns
// either a constant texel or an address-derived pattern {0, x, y}.
module tb_platform_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount, vcount;
    logic        video_on, frame_tick, scroll_en;
    logic [2:0]  scroll_speed;
    logic [11:0] bg_color;
    logic [5:0]  rom_x;
    logic [4:0]  rom_y;
    logic        rom_en;
    logic [11:0] rom_color;
    logic [11:0] pix_color;
    logic        pix_valid, in_platform;

    int testsRun    = 0;
    int testsFailed = 0;

    logic        romMode;
    logic [11:0] romConst;
    logic [11:0] romStage1, romStage2;

    always #5 clk = ~clk;

    platform_renderer dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .frame_tick(frame_tick), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
        .bg_color(bg_color), .rom_x(rom_x), .rom_y(rom_y), .rom_en(rom_en),
        .rom_color(rom_color), .pix_color(pix_color), .pix_valid(pix_valid),
        .in_platform(in_platform)
    );

    // ROM model: address registered into stage 1, texel presented from stage 2
    always @(posedge clk) begin
        romStage1 <= romMode ? {1'b0, rom_x, rom_y} : romConst;
        romStage2 <= romStage1;
    end
    assign rom_color = romStage2;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic von,
                                 input logic [11:0] bg);
        hcount   = h;
        vcount   = v;
        video_on = von;
        bg_color = bg;
    endtask

    task automatic pulseTick();
        frame_tick = 1'b1;
        waitCycles(1);
        frame_tick = 1'b0;
    endtask

    logic [9:0] sweepV   [4] = '{10'd415, 10'd416, 10'd447, 10'd448};
    logic       sweepHit [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] sweepY   [4] = '{5'd0, 5'd0, 5'd31, 5'd0};

    initial begin
        rst_n        = 1'b0;
        frame_tick   = 1'b0;
        scroll_en    = 1'b0;
        scroll_speed = 3'd0;
        romMode      = 1'b0;
        romConst     = 12'h123;
        applyStimulus(10'd0, 10'd0, 1'b0, 12'h000);
        waitCycles(3);
        checkOutput("reset rom_x", 32'(rom_x), 32'd0);
        checkOutput("reset rom_y", 32'(rom_y), 32'd0);
        checkOutput("reset rom_en", 32'(rom_en), 32'd0);
        checkOutput("reset pix_color", 32'(pix_color), 32'd0);
        checkOutput("reset pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("reset in_platform", 32'(in_platform), 32'd0);

        // Opaque texel inside the strip
        rst_n = 1'b1;
        applyStimulus(10'd5, 10'd420, 1'b1, 12'h08F);
        waitCycles(1);
        checkOutput("t1 rom_x", 32'(rom_x), 32'd5);
        checkOutput("t1 rom_y", 32'(rom_y), 32'd4);
        checkOutput("t1 rom_en", 32'(rom_en), 32'd1);
        waitCycles(3);
        checkOutput("t1 pix_color", 32'(pix_color), 32'h123);
        checkOutput("t1 in_platform", 32'(in_platform), 32'd1);
        checkOutput("t1 pix_valid", 32'(pix_valid), 32'd1);

        // Transparent key shows background
        romConst = 12'hF0F;
        waitCycles(4);
        checkOutput("t2 pix_color", 32'(pix_color), 32'h08F);
        checkOutput("t2 pix_valid", 32'(pix_valid), 32'd1);
        checkOutput("t2 in_platform", 32'(in_platform), 32'd0);

        // Vertical strip boundaries
        romConst = 12'h123;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(10'd5, sweepV[i], 1'b1, 12'h08F);
            waitCycles(4);
            checkOutput($sformatf("t3 in_platform v=%0d", sweepV[i]), 32'(in_platform),
                        32'(sweepHit[i]));
            checkOutput($sformatf("t3 pix_color v=%0d", sweepV[i]), 32'(pix_color),
                        sweepHit[i] ? 32'h123 : 32'h08F);
            if (sweepHit[i])
                checkOutput($sformatf("t3 rom_y v=%0d", sweepV[i]), 32'(rom_y), 32'(sweepY[i]));
        end

        // Blanking and horizontal limit
        applyStimulus(10'd700, 10'd420, 1'b0, 12'h0F0);
        waitCycles(4);
        checkOutput("t5 blank pix_color", 32'(pix_color), 32'd0);
        checkOutput("t5 blank pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("t5 blank in_platform", 32'(in_platform), 32'd0);
        applyStimulus(10'd640, 10'd420, 1'b1, 12'h0F0);
        waitCycles(4);
        checkOutput("t5 h640 in_platform", 32'(in_platform), 32'd0);
        checkOutput("t5 h640 pix_color", 32'(pix_color), 32'h0F0);
        checkOutput("t5 h640 pix_valid", 32'(pix_valid), 32'd1);

        // Scroll: 21 ticks of 3 reach 63, one more wraps to 2
        applyStimulus(10'd0, 10'd420, 1'b1, 12'h0F0);
        scroll_en    = 1'b1;
        scroll_speed = 3'd3;
        repeat (21) pulseTick();
        waitCycles(1);
        checkOutput("t4 scroll 63", 32'(rom_x), 32'd63);
        applyStimulus(10'd5, 10'd420, 1'b1, 12'h0F0);
        waitCycles(1);
        checkOutput("t4 x wrap 5+63", 32'(rom_x), 32'd4);
        applyStimulus(10'd0, 10'd420, 1'b1, 12'h0F0);
        pulseTick();
        waitCycles(1);
        checkOutput("t4 scroll 63+3", 32'(rom_x), 32'd2);
        scroll_en = 1'b0;
        repeat (3) pulseTick();
        waitCycles(1);
        checkOutput("t4 scroll_en=0 hold", 32'(rom_x), 32'd2);
        scroll_en    = 1'b1;
        scroll_speed = 3'd0;
        pulseTick();
        waitCycles(1);
        checkOutput("t4 speed0 hold", 32'(rom_x), 32'd2);
        scroll_speed = 3'd5;
        repeat (12) pulseTick();
        waitCycles(1);
        checkOutput("t4 scroll 62", 32'(rom_x), 32'd62);
        scroll_speed = 3'd3;
        pulseTick();
        waitCycles(1);
        checkOutput("t4 scroll 62+3", 32'(rom_x), 32'd1);
        scroll_en = 1'b0;

        // Address-derived texel through the full pipeline: x=10+1, y=430-416
        romMode = 1'b1;
        applyStimulus(10'd10, 10'd430, 1'b1, 12'h0F0);
        waitCycles(4);
        checkOutput("pattern pix_color", 32'(pix_color), 32'h16E);
        checkOutput("pattern in_platform", 32'(in_platform), 32'd1);

        // Reset pulse mid-strip clears everything
        romMode = 1'b0;
        applyStimulus(10'd5, 10'd420, 1'b1, 12'h08F);
        waitCycles(4);
        checkOutput("t6 pre in_platform", 32'(in_platform), 32'd1);
        rst_n = 1'b0;
        waitCycles(1);
        checkOutput("t6 rst rom_x", 32'(rom_x), 32'd0);
        checkOutput("t6 rst rom_y", 32'(rom_y), 32'd0);
        checkOutput("t6 rst rom_en", 32'(rom_en), 32'd0);
        checkOutput("t6 rst pix_color", 32'(pix_color), 32'd0);
        checkOutput("t6 rst pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("t6 rst in_platform", 32'(in_platform), 32'd0);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("t6 rom_x scroll cleared", 32'(rom_x), 32'd5);
        checkOutput("t6 cycle1 pix_valid", 32'(pix_valid), 32'd0);
        waitCycles(2);
        checkOutput("t6 cycle3 pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("t6 cycle3 in_platform", 32'(in_platform), 32'd0);
        waitCycles(1);
        checkOutput("t6 cycle4 pix_valid", 32'(pix_valid), 32'd1);
        checkOutput("t6 cycle4 pix_color", 32'(pix_color), 32'h123);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
